// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch / PC stage with request-ready fetch handshake and retired-instruction counter.
// Ports: clk, rst_n (async, active-low); PC_next, stall from datapath; ireq/iaddr out, irdy/idata in (instruction memory);
//        PC_curr, instr, instr_valid, fetch_err, instret out.
// Macro FETCH_MISALIGN_TRAP_EN: a misaligned committed PC halts with fetch_err; otherwise the low PC bits are cleared.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_next,
  input  logic        stall,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        irdy,
  input  logic [31:0] idata,
  output logic [31:0] PC_curr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instret
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, pc_commit;
  logic        commit, trap, fetch_done;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap      = |PC_next[1:0];
  assign pc_commit = PC_next;
`else
  assign trap      = 1'b0;
  assign pc_commit = PC_next & ~32'h3;
`endif
  assign fetch_done = state_q == FETCH && irdy;
  assign commit     = state_q == EXEC && !stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    state_d   = fetch_done ? EXEC : commit ? (trap ? HALT : FETCH) : state_q;
    pc_d      = commit ? pc_commit : pc_q;
    instr_d   = fetch_done ? idata : commit ? NOP_INSTR : instr_q;
    instret_d = commit ? instret_q + 32'd1 : instret_q;
  end
  // ireq is gated by rst_n so an in-flight request is abandoned the moment reset asserts.
  always_comb begin
    ireq        = rst_n && state_q == FETCH;
    iaddr       = pc_q;
    PC_curr     = pc_q;
    instr       = instr_q;
    instr_valid = state_q == EXEC;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_err   = state_q == HALT;
`else
    fetch_err   = 1'b0;
`endif
    instret     = instret_q;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter stage of the single-cycle RV32I core. Owns the architectural PC register and drives `PC_curr` to the decode/control datapath. Fetches each instruction from instruction memory over a request/ready handshake and presents it to the datapath. Commits the datapath's combinational `PC_next` once the instruction retires. Also keeps a retired-instruction counter.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC after reset. Must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013: value of `instr` whenever no valid instruction is held (ADDI x0,x0,0).

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `PC_next` input 32: next PC from the control block; sampled only at commit.
- `stall` input 1: datapath not ready to retire (e.g. data-memory wait); holds the current instruction.
- `ireq` output 1: instruction-memory request.
- `iaddr` output 32: fetch address; always equals `PC_curr`.
- `irdy` input 1: instruction memory has `idata` valid for `iaddr`.
- `idata` input 32: instruction word from memory.
- `PC_curr` output 32: architectural PC of the held instruction.
- `instr` output 32: held instruction word.
- `instr_valid` output 1: `instr` is valid; datapath side effects are enabled only while this is high.
- `fetch_err` output 1: misaligned-PC fault; only with `FETCH_MISALIGN_TRAP_EN`, otherwise tied 0.
- `instret` output 32: count of retired instructions.

## Operation

**State machine: FETCH, EXEC, HALT.**
- **Reset (async, `rst_n`=0):**
  - State = FETCH.
  - `PC_curr` = `RESET_PC`, `instr` = `NOP_INSTR`.
  - `instr_valid` = 0, `fetch_err` = 0, `instret` = 0.
  - `ireq` = 0 while reset is asserted.
- **FETCH:**
  - `ireq` = 1 and `iaddr` = `PC_curr`, both combinational from state.
  - The address is held stable until `irdy` is sampled high.
  - On an edge with `irdy`=1: `instr` <= `idata`, state goes to EXEC.
  - `irdy` in the same cycle `ireq` rises is legal (zero-wait memory).
- **EXEC:**
  - `instr_valid` = 1 and `ireq` = 0.
  - `irdy` is ignored whenever `ireq`=0.
  - On an edge with `stall`=1: everything holds. `PC_curr`, `instr` and `instret` are unchanged.
  - On an edge with `stall`=0 (commit):
    - `PC_curr` <= `PC_next`.
    - `instret` <= `instret` + 1. It wraps from 32'hFFFF_FFFF to 0.
    - `instr` <= `NOP_INSTR`.
    - State goes to FETCH, unless a misalignment trap applies (see Configuration).
- **HALT:**
  - `ireq` = 0, `instr_valid` = 0, `fetch_err` = 1.
  - Only `rst_n` exits this state.
- A `PC_next` that equals `PC_curr` (self-loop) is legal: the same address is re-fetched.
- Reset mid-request: `ireq` drops immediately. Memory must tolerate an abandoned request.

## Timing

- Minimum 2 cycles per instruction: one FETCH cycle with `irdy`=1, then one EXEC cycle.
- Each FETCH cycle with `irdy`=0 adds 1 cycle.
- Each EXEC cycle with `stall`=1 adds 1 cycle.
- `PC_curr`, `instr`, `instr_valid` and `fetch_err` are registered or decoded from state only. There is no combinational path from `PC_next`, `stall`, `irdy` or `idata` to any output.
- `ireq` and `iaddr` are functions of state and `PC_curr` only.
- `instret` is registered. It updates on the commit edge and is visible the cycle after.

## Configuration

Macro: `FETCH_MISALIGN_TRAP_EN`.

- **Defined:** at a commit edge, if `PC_next[1:0]` != 0:
  - `PC_curr` <= `PC_next` (the faulting address is kept).
  - `instret` increments.
  - State goes to HALT.
- **Undefined:**
  - `PC_curr` <= {`PC_next[31:2]`, 2'b00}; the low bits are silently cleared.
  - HALT is unreachable and `fetch_err` is constant 0.

## Test plan

- **Reset and first fetch:** release `rst_n` with memory `irdy` tied 1 and `idata`=32'h0050_0093.
  - Next edge: `ireq`=1, `iaddr`=0.
  - Following cycle: `instr`=32'h0050_0093, `instr_valid`=1.
- **Wait states:** `irdy` low for 3 cycles after `ireq` rises.
  - `iaddr` is stable at `PC_curr` throughout.
  - `instr_valid` rises exactly 1 cycle after the `irdy` edge.
- **Stall hold:** in EXEC, `stall`=1 for 4 cycles with `PC_next`=32'h40.
  - `PC_curr`, `instr` and `instret` are unchanged for all 4 cycles.
  - On the `stall`=0 edge: `PC_curr`=32'h40, `instret`+1.
- **Branch/jump commit:** `PC_curr`=32'h100, `PC_next`=32'h0F8.
  - Next `iaddr`=32'h0F8; 2-cycle throughput holds with zero-wait memory.
- **Misaligned `PC_next`=32'h102:**
  - With the macro: HALT, `fetch_err`=1, `PC_curr`=32'h102, `ireq` stays 0.
  - Without the macro: `PC_curr`=32'h100 and fetching continues.
- **Async reset mid-FETCH and counter wrap:**
  - Assert `rst_n`=0 between edges: `ireq` falls at once, `PC_curr`=`RESET_PC`.
  - Force `instret`=32'hFFFF_FFFF and then commit: `instret`=0.
